node_pack_upsize: RTL and testbench

Valid/ready width upsizer that sits directly downstream of a single-register valid/ready pipeline node. It collects RATIO narrow beats into one wide word, and a packet may close early with a last flag. It presents the wide word with a lane-keep mask on a registered valid/ready output. Ready toward upstream depends only on registered state and `dn_ready_in`, so nodes can be chained without a combinational valid-to-ready path.

---
 rtl/node_pack_upsize_pkg.sv | 14 +
 rtl/node_pack_upsize_if.sv | 31 +++
 rtl/node_pack_upsize_lane_acc.sv | 63 ++++++
 rtl/node_pack_upsize.sv | 105 ++++++++++
 tb/tb_node_pack_upsize.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/node_pack_upsize_pkg.sv
// Shared defaults and helpers for the narrow-to-wide packing node.
package node_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_RATIO = 4;

  // Lane counter width: enough to index RATIO lanes, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned ratio);
    int unsigned w;
    w = $clog2(ratio);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/node_pack_upsize_if.sv
// Upstream narrow and downstream wide valid/ready signals of the packing node.
interface node_pack_upsize_if
  import node_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RATIO = DEF_RATIO
);

  logic [WIDTH-1:0]       data_in;
  logic                   up_last_in;
  logic                   up_valid_in;
  logic                   up_ready_out;
  logic [WIDTH*RATIO-1:0] data_out;
  logic [RATIO-1:0]       keep_out;
  logic                   last_out;
  logic                   dn_valid_out;
  logic                   dn_ready_in;

  // Packing node side.
  modport slave (
    input  data_in, up_last_in, up_valid_in, dn_ready_in,
    output up_ready_out, data_out, keep_out, last_out, dn_valid_out
  );

  // Environment side: drives narrow beats, consumes wide words.
  modport master (
    output data_in, up_last_in, up_valid_in, dn_ready_in,
    input  up_ready_out, data_out, keep_out, last_out, dn_valid_out
  );

endinterface

// File: rtl/node_pack_upsize_lane_acc.sv
// Partial-word accumulator: lanes 0..RATIO-2, their keep bits and the lane counter.
module pack_lane_acc
  import node_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RATIO = DEF_RATIO,
  localparam int unsigned CNT_W = cnt_w(RATIO),
  localparam int unsigned ACC_W = WIDTH * (RATIO - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             beat_fire,
  input  logic             beat_last,
  input  logic [WIDTH-1:0] beat_data,
  output logic [CNT_W-1:0] cnt,
  output logic [ACC_W-1:0] acc_data,
  output logic [RATIO-2:0] acc_keep,
  output logic             complete_c
);

  logic [CNT_W-1:0] cnt_d;
  logic [ACC_W-1:0] acc_data_d;
  logic [RATIO-2:0] acc_keep_d;

  // A beat closes the word when it fills the top lane or carries last.
  assign complete_c = (cnt == CNT_W'(RATIO - 1)) | beat_last;

  // Next-state: store a non-closing beat in lane cnt, or empty out on a closing beat.
  always_comb begin
    cnt_d      = cnt;
    acc_data_d = acc_data;
    acc_keep_d = acc_keep;
    if (beat_fire) begin
      if (complete_c) begin
        cnt_d      = '0;
        acc_data_d = '0;
        acc_keep_d = '0;
      end else begin
        for (int k = 0; k < int'(RATIO) - 1; k++) begin
          if (cnt == CNT_W'(k)) begin
            acc_data_d[k*WIDTH +: WIDTH] = beat_data;
            acc_keep_d[k]                = 1'b1;
          end
        end
        cnt_d = cnt + CNT_W'(1);
      end
    end
  end

  // Accumulator state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      acc_data <= '0;
      acc_keep <= '0;
    end else begin
      cnt      <= cnt_d;
      acc_data <= acc_data_d;
      acc_keep <= acc_keep_d;
    end
  end

endmodule

// File: rtl/node_pack_upsize.sv
// Valid/ready width upsizer: packs RATIO narrow beats (or fewer, on last) into one wide word.
module node_pack_upsize
  import node_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned RATIO = DEF_RATIO
) (
  input logic               clk,
  input logic               rst,
  node_pack_upsize_if.slave bus
);

  localparam int unsigned CNT_W  = cnt_w(RATIO);
  localparam int unsigned WORD_W = WIDTH * RATIO;
  localparam int unsigned ACC_W  = WIDTH * (RATIO - 1);

  typedef logic [RATIO-1:0]  keep_t;
  typedef logic [WORD_W-1:0] word_t;

  logic             up_ready_c;
  logic             up_fire_c;
  logic             dn_fire_c;
  logic             complete_c;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc_data;
  logic [RATIO-2:0] acc_keep;

  word_t word_c;
  keep_t keep_c;

  word_t data_q, data_d;
  keep_t keep_q, keep_d;
  logic  last_q, last_d;
  logic  valid_q, valid_d;

  // Ready looks only at the output register and downstream ready, never at upstream valid.
  assign up_ready_c = ~rst & (~valid_q | bus.dn_ready_in);
  assign up_fire_c  = bus.up_valid_in & up_ready_c;
  assign dn_fire_c  = valid_q & bus.dn_ready_in;

  pack_lane_acc #(
    .WIDTH (WIDTH),
    .RATIO (RATIO)
  ) u_acc (
    .clk        (clk),
    .rst        (rst),
    .beat_fire  (up_fire_c),
    .beat_last  (bus.up_last_in),
    .beat_data  (bus.data_in),
    .cnt        (cnt),
    .acc_data   (acc_data),
    .acc_keep   (acc_keep),
    .complete_c (complete_c)
  );

  // Closing word: accumulated lanes (zero above cnt) with the incoming beat in lane cnt.
  always_comb begin
    word_c = WORD_W'(acc_data);
    keep_c = RATIO'(acc_keep);
    for (int k = 0; k < int'(RATIO); k++) begin
      if (cnt == CNT_W'(k)) begin
        word_c[k*WIDTH +: WIDTH] = bus.data_in;
        keep_c[k]                = 1'b1;
      end
    end
  end

  // Output register next-state: load a closed word, else drop valid once consumed.
  always_comb begin
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    valid_d = valid_q;
    if (up_fire_c && complete_c) begin
      data_d  = word_c;
      keep_d  = keep_c;
      last_d  = bus.up_last_in;
      valid_d = 1'b1;
    end else if (dn_fire_c) begin
      valid_d = 1'b0;
    end
  end

  // Output register with synchronous reset; discards any pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign bus.up_ready_out = up_ready_c;
  assign bus.data_out     = data_q;
  assign bus.keep_out     = keep_q;
  assign bus.last_out     = last_q;
  assign bus.dn_valid_out = valid_q;

endmodule

// File: tb/tb_node_pack_upsize.sv
// Scoreboard bench for node_pack_upsize (WIDTH=32, RATIO=4).
module tb_node_pack_upsize;

  localparam int unsigned W = 32;
  localparam int unsigned R = 4;

  typedef struct {
    logic [127:0] d;
    logic [3:0]   k;
    logic         l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  node_pack_upsize_if #(.WIDTH(W), .RATIO(R)) bus();

  node_pack_upsize #(.WIDTH(W), .RATIO(R)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [127:0] w4(input logic [31:0] l0, input logic [31:0] l1,
                                      input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  task automatic push(input logic [127:0] d, input logic [3:0] k, input logic l);
    exp_t e;
    e.d = d;
    e.k = k;
    e.l = l;
    sb.push_back(e);
  endtask

  // Present one beat from posedge+1; returns the number of cycles spent waiting for ready.
  task automatic send(input logic [31:0] d, input logic l, output int waits);
    waits = 0;
    bus.up_valid_in = 1'b1;
    bus.data_in     = d;
    bus.up_last_in  = l;
    @(negedge clk);
    while (bus.up_ready_out !== 1'b1 && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 100) chk("accept_timeout", 128'(waits), 128'(0));
    @(posedge clk);
    #1;
    bus.up_valid_in = 1'b0;
    bus.up_last_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every accepted wide word must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.dn_valid_out === 1'b1 && bus.dn_ready_in === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", bus.data_out, 128'(0));
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("word_data", bus.data_out, e.d);
          chk("word_keep", 128'(bus.keep_out), 128'(e.k));
          chk("word_last", 128'(bus.last_out), 128'(e.l));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  initial begin
    int wt;
    rst             = 1'b1;
    bus.up_valid_in = 1'b0;
    bus.up_last_in  = 1'b0;
    bus.data_in     = '0;
    bus.dn_ready_in = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_up_ready", 128'(bus.up_ready_out), 128'(0));
    chk("rst_dn_valid", 128'(bus.dn_valid_out), 128'(0));
    chk("rst_data",     bus.data_out,           128'(0));
    chk("rst_keep",     128'(bus.keep_out),     128'(0));
    chk("rst_last",     128'(bus.last_out),     128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_up_ready", 128'(bus.up_ready_out), 128'(1));
    @(posedge clk);
    #1;

    // Full word
    push(w4(32'h11, 32'h22, 32'h33, 32'h44), 4'b1111, 1'b0);
    send(32'h11, 1'b0, wt);
    send(32'h22, 1'b0, wt);
    send(32'h33, 1'b0, wt);
    send(32'h44, 1'b0, wt);
    chk("full_latency_valid", 128'(bus.dn_valid_out), 128'(1));

    // Early last, then the next beat lands in lane 0
    push(w4(32'hAA, 32'hBB, 32'h0, 32'h0), 4'b0011, 1'b1);
    send(32'hAA, 1'b0, wt);
    send(32'hBB, 1'b1, wt);
    chk("early_latency_valid", 128'(bus.dn_valid_out), 128'(1));
    push(w4(32'hCC, 32'h0, 32'h0, 32'h0), 4'b0001, 1'b1);
    send(32'hCC, 1'b1, wt);
    idle(2);

    // Backpressure: word held stable for 5 cycles, then one consumption
    bus.dn_ready_in = 1'b0;
    push(w4(32'hB1, 32'hB2, 32'hB3, 32'hB4), 4'b1111, 1'b0);
    send(32'hB1, 1'b0, wt);
    send(32'hB2, 1'b0, wt);
    send(32'hB3, 1'b0, wt);
    send(32'hB4, 1'b0, wt);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_up_ready", 128'(bus.up_ready_out), 128'(0));
      chk("bp_dn_valid", 128'(bus.dn_valid_out), 128'(1));
      chk("bp_data",     bus.data_out, w4(32'hB1, 32'hB2, 32'hB3, 32'hB4));
      chk("bp_keep",     128'(bus.keep_out), 128'(4'b1111));
    end
    @(posedge clk);
    #1;
    bus.dn_ready_in = 1'b1;
    @(negedge clk);
    chk("bp_release_up_ready", 128'(bus.up_ready_out), 128'(1));
    @(posedge clk);
    #1;
    chk("bp_single_fire", 128'(bus.dn_valid_out), 128'(0));

    // Continuous stream of 8 beats: ready must never drop
    push(w4(32'd1, 32'd2, 32'd3, 32'd4), 4'b1111, 1'b0);
    push(w4(32'd5, 32'd6, 32'd7, 32'd8), 4'b1111, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      send(32'(i), 1'b0, wt);
      chk("stream_no_wait", 128'(wt), 128'(0));
    end

    // Simultaneous consume of the pending word and load of a new one
    push(w4(32'h55, 32'h0, 32'h0, 32'h0), 4'b0001, 1'b1);
    send(32'h55, 1'b1, wt);
    chk("sim_no_wait",  128'(wt), 128'(0));
    chk("sim_dn_valid", 128'(bus.dn_valid_out), 128'(1));
    chk("sim_data",     bus.data_out, w4(32'h55, 32'h0, 32'h0, 32'h0));
    idle(2);

    // Reset mid-packet discards the partial word
    send(32'hA0, 1'b0, wt);
    send(32'hA1, 1'b0, wt);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_up_ready", 128'(bus.up_ready_out), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_release_ready", 128'(bus.up_ready_out), 128'(1));
    chk("midrst_dn_valid",      128'(bus.dn_valid_out), 128'(0));
    @(posedge clk);
    #1;
    push(w4(32'h1, 32'h2, 32'h3, 32'h4), 4'b1111, 1'b0);
    send(32'h1, 1'b0, wt);
    send(32'h2, 1'b0, wt);
    send(32'h3, 1'b0, wt);
    send(32'h4, 1'b0, wt);

    // Drain scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", 128'(sb.size()), 128'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
